register_bank: RTL

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 10 +
 rtl/register_bank_reg_cell.sv | 21 ++
 rtl/register_bank.sv | 103 ++++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared sizing constants for the register bank: data width, register count,
// index width and the slot that acts as the program counter.
package register_bank_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREG   = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned PC_IDX = 7;

endpackage

// File: rtl/register_bank_reg_cell.sv
// Single storage register with asynchronous active-low reset and a load enable;
// the bank instantiates one per architectural register.
module reg_cell #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Eight-entry register bank with write, register-to-register move and a
// program-counter increment on register 7; all outputs come straight from flops.
module register_bank #(
    parameter int unsigned DATA_W = register_bank_pkg::DATA_W,
    parameter int unsigned NREG   = register_bank_pkg::NREG
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                wr_en,
    input  logic [register_bank_pkg::ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    input  logic                                mov_en,
    input  logic [register_bank_pkg::ADDR_W-1:0] mov_src,
    input  logic [register_bank_pkg::ADDR_W-1:0] mov_dst,
    input  logic                                pc_inc,
    output logic [DATA_W-1:0]                   reg0,
    output logic [DATA_W-1:0]                   reg1,
    output logic [DATA_W-1:0]                   reg2,
    output logic [DATA_W-1:0]                   reg3,
    output logic [DATA_W-1:0]                   reg4,
    output logic [DATA_W-1:0]                   reg5,
    output logic [DATA_W-1:0]                   reg6,
    output logic [DATA_W-1:0]                   reg7,
    output logic                                pc_wrap,
    output logic                                wr_conflict
);

    import register_bank_pkg::*;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] nxt  [NREG];
    logic [NREG-1:0]   ld;
    logic              wr_pc;
    logic              mov_pc;
    logic              wrap_d;
    logic              conf_d;
    logic              pc_wrap_q;
    logic              wr_conflict_q;

    // Per-register priority: clr, write, move, increment. Moves read the
    // current flop outputs, so a same-cycle write is never forwarded.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            ld[i]  = 1'b0;
            nxt[i] = regs[i];
            if (clr) begin
                ld[i]  = 1'b1;
                nxt[i] = '0;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                ld[i]  = 1'b1;
                nxt[i] = wr_data;
            end else if (mov_en && (mov_dst == ADDR_W'(i))) begin
                ld[i]  = 1'b1;
                nxt[i] = regs[mov_src];
            end else if (pc_inc && (i == PC_IDX)) begin
                ld[i]  = 1'b1;
                nxt[i] = regs[i] + DATA_W'(1);
            end
        end
    end

    always_comb begin
        wr_pc  = wr_en && (wr_addr == ADDR_W'(PC_IDX));
        mov_pc = mov_en && (mov_dst == ADDR_W'(PC_IDX));
        wrap_d = !clr && pc_inc && !wr_pc && !mov_pc && (regs[PC_IDX] == '1);
        conf_d = !clr && wr_en && mov_en && (wr_addr == mov_dst) && (mov_src != mov_dst);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_wrap_q     <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            pc_wrap_q     <= wrap_d;
            wr_conflict_q <= conf_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_cell
        reg_cell #(
            .W (DATA_W)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld[g]),
            .d     (nxt[g]),
            .q     (regs[g])
        );
    end

    assign reg0        = regs[0];
    assign reg1        = regs[1];
    assign reg2        = regs[2];
    assign reg3        = regs[3];
    assign reg4        = regs[4];
    assign reg5        = regs[5];
    assign reg6        = regs[6];
    assign reg7        = regs[7];
    assign pc_wrap     = pc_wrap_q;
    assign wr_conflict = wr_conflict_q;

endmodule
